// File: rtl/iq_sweep_ctrl.sv
// Frequency-sweep scheduler: retunes the IQ datapath, waits for it to settle,
// then averages |q| over a fixed number of strobed samples per tuning word.
module iq_sweep_ctrl #(
  parameter int FTW_W         = 8,
  parameter int DATA_W        = 24,
  parameter int SETTLE_CYCLES = 64,
  parameter int AVG_LOG2      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [FTW_W-1:0]  ftw_start,
  input  logic [FTW_W-1:0]  ftw_step,
  input  logic [7:0]        num_steps,
  input  logic              sample_valid_in,
  input  logic [DATA_W-1:0] sample_in,
  output logic [FTW_W-1:0]  ftw_out,
  output logic              busy,
  output logic              result_valid,
  output logic [FTW_W-1:0]  result_ftw,
  output logic [DATA_W-1:0] result_mag,
  output logic              done
);

  localparam int ACC_W = DATA_W + AVG_LOG2;

  typedef enum logic [2:0] {IDLE, SETTLE, ACCUM, REPORT, DONE} state_t;

  state_t              state, state_nxt;
  logic [15:0]         settle_cnt;
  logic [AVG_LOG2-1:0] smp_cnt;
  logic [ACC_W-1:0]    acc;
  logic [FTW_W-1:0]    step_q;
  logic [7:0]          steps_left;

  logic [DATA_W-1:0]   smp_abs;
  logic [ACC_W-1:0]    acc_sum;
  logic                settle_end, smp_take, smp_last, more_steps, abort_act;

  always_comb begin
    smp_abs = sample_in;
    // the most negative code has no positive twin; clamp it to full scale
    if (sample_in[DATA_W-1])
      smp_abs = (sample_in == {1'b1, {(DATA_W-1){1'b0}}}) ? {1'b0, {(DATA_W-1){1'b1}}}
                                                          : -sample_in;
    acc_sum    = acc + ACC_W'(smp_abs);
    settle_end = (state == SETTLE) && (settle_cnt == 16'(SETTLE_CYCLES - 1));
    smp_take   = (state == ACCUM) && sample_valid_in;
    smp_last   = smp_take && (&smp_cnt);
    more_steps = (steps_left != 8'd1);
    abort_act  = abort && (state inside {SETTLE, ACCUM, REPORT});
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_steps == 8'd0) ? DONE : SETTLE;
      SETTLE:  if (settle_end) state_nxt = ACCUM;
      ACCUM:   if (smp_last) state_nxt = REPORT;
      REPORT:  state_nxt = more_steps ? SETTLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_act) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ftw_out      <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_ftw   <= '0;
      result_mag   <= '0;
      done         <= 1'b0;
      settle_cnt   <= '0;
      smp_cnt      <= '0;
      acc          <= '0;
      step_q       <= '0;
      steps_left   <= '0;
    end else begin
      // strobes and busy are decoded from the next state so they line up with it
      busy         <= state_nxt inside {SETTLE, ACCUM, REPORT};
      result_valid <= (state_nxt == REPORT);
      done         <= (state_nxt == DONE);
      case (state)
        IDLE: if (start && num_steps != 8'd0) begin
          ftw_out    <= ftw_start;
          step_q     <= ftw_step;
          steps_left <= num_steps;
          settle_cnt <= '0;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 16'd1;
          if (settle_end) begin
            smp_cnt <= '0;
            acc     <= '0;
          end
        end
        ACCUM: if (smp_take) begin
          acc     <= acc_sum;
          smp_cnt <= smp_cnt + AVG_LOG2'(1);
          if (smp_last && !abort) begin
            result_ftw <= ftw_out;
            result_mag <= acc_sum[ACC_W-1:AVG_LOG2];
          end
        end
        REPORT: if (!abort) begin
          steps_left <= steps_left - 8'd1;
          if (more_steps) begin
            ftw_out    <= ftw_out + step_q;
            settle_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
